// File: rtl/step_pulse_pkg.sv
// -----------------------------------------------------------------------------
// step_pulse_pkg
//   Shared definitions for the step pulse conditioner: debounce FSM state
//   encoding, default timing constants and a counter-width helper.
// -----------------------------------------------------------------------------
package step_pulse_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  // 10 ms of stable level at 100 MHz.
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
  // 0.5 s between auto-repeat steps at 100 MHz.
  localparam int unsigned DEFAULT_REPEAT_CYCLES   = 50_000_000;

  // $clog2(1) is 0, which would give a zero-width counter; a one-cycle
  // window still needs a 1-bit counter holding the value 0.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/step_pulse_conditioner_if.sv
// -----------------------------------------------------------------------------
// step_pulse_conditioner_if
//   Bundles the raw board inputs and the conditioned outputs of the step
//   pulse conditioner.
//   btn_in     raw, bouncy, asynchronous step button
//   sw_in      raw, asynchronous w switch
//   step       one-cycle pulse per accepted press (or repeat)
//   w_out      synchronized switch value captured on each step
//   btn_level  debounced button level
//   master: the side that drives the raw inputs (board / testbench)
//   slave : the conditioner itself
// -----------------------------------------------------------------------------
interface step_pulse_conditioner_if;

  logic btn_in;
  logic sw_in;
  logic step;
  logic w_out;
  logic btn_level;

  modport master (
    output btn_in,
    output sw_in,
    input  step,
    input  w_out,
    input  btn_level
  );

  modport slave (
    input  btn_in,
    input  sw_in,
    output step,
    output w_out,
    output btn_level
  );

endinterface

// File: rtl/step_pulse_conditioner_sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
//   Two-flop synchronizer for one asynchronous bit, reset to 0.
//   clk    destination clock
//   reset  asynchronous, active-high
//   d      asynchronous input
//   q      synchronized output (second stage)
// -----------------------------------------------------------------------------
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/step_pulse_conditioner.sv
// -----------------------------------------------------------------------------
// step_pulse_conditioner
//   Input conditioning ahead of the sequence-detector FSM. Synchronizes and
//   debounces the step button, synchronizes the w switch, and emits one
//   registered step pulse per clean press together with the switch value
//   captured on that same edge. The downstream FSM advances on step and reads
//   w_out instead of being clocked from the button.
//   Board wiring: btnC -> btn_in, sw -> sw_in, btnU -> reset.
//
// Ports
//   clk        board clock, all logic on the rising edge
//   reset      asynchronous, active-high; clears all state
//   bus.btn_in raw step button        bus.sw_in     raw w switch
//   bus.step   one-cycle step pulse   bus.w_out     switch value held from last step
//   bus.btn_level  debounced button level (1 in PRESSED / RELEASE_WAIT)
//
// Parameters
//   DEBOUNCE_CYCLES  cycles of stable level needed to accept a press/release
//   REPEAT_CYCLES    cycles between auto-repeat steps while held
//                    (present only with STEP_PULSE_REPEAT_EN)
//
// Build option
//   STEP_PULSE_REPEAT_EN  defined: holding the button emits a further step
//                         every REPEAT_CYCLES cycles. Undefined: exactly one
//                         step per press and no repeat counter exists.
// -----------------------------------------------------------------------------
module step_pulse_conditioner
  import step_pulse_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
`ifdef STEP_PULSE_REPEAT_EN
  ,
  parameter int unsigned REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
`endif
) (
  input  logic                      clk,
  input  logic                      reset,
  step_pulse_conditioner_if.slave   bus
);

  localparam int unsigned          CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic              press_accept;
  logic              rpt_fire;
  logic              btn_s;
  logic              sw_s;
  logic              step_q;
  logic              step_next;
  logic              w_q;
  logic              w_next;

  sync_2ff u_btn_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.btn_in),
    .q     (btn_s)
  );

  sync_2ff u_sw_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.sw_in),
    .q     (sw_s)
  );

  // NOTE: state lives in always_ff with non-blocking assignments so every
  // register samples the pre-edge values of its neighbours, as hardware does.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      step_q <= 1'b0;
      w_q    <= 1'b0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      step_q <= step_next;
      w_q    <= w_next;
    end
  end

  // Debounce FSM. A press is accepted only after btn_s has stayed high for
  // the whole PRESS_WAIT window; a release likewise needs a full
  // RELEASE_WAIT window of low samples. Any contrary sample aborts the window.
  always_comb begin
    // NOTE: every output of this block is defaulted first so that no path
    // leaves a variable unassigned and a latch can never be inferred.
    state_next   = state;
    cnt_next     = cnt;
    press_accept = 1'b0;

    case (state)
      IDLE: begin
        if (btn_s) state_next = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          state_next = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_next   = PRESSED;
          press_accept = 1'b1;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!btn_s) state_next = RELEASE_WAIT;
      end
      RELEASE_WAIT: begin
        if (btn_s) begin
          // Bounce during release: back to PRESSED without a new step.
          state_next = PRESSED;
        end else if (cnt == CNT_LAST) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Each window starts counting from zero, whichever way it was entered.
    if (state_next != state) cnt_next = '0;
  end

`ifdef STEP_PULSE_REPEAT_EN
  localparam int unsigned          RPT_W    = cnt_width(REPEAT_CYCLES);
  localparam logic [RPT_W-1:0]     RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

  logic [RPT_W-1:0] rpt;
  logic [RPT_W-1:0] rpt_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rpt <= '0;
    else       rpt <= rpt_next;
  end

  // rpt only advances while the button sits stably in PRESSED; any other
  // state (including the release window) holds it at zero, so a bounce back
  // into PRESSED restarts the full repeat interval.
  always_comb begin
    rpt_next = '0;
    rpt_fire = 1'b0;
    if (state == PRESSED && btn_s) begin
      if (rpt == RPT_LAST) rpt_fire = 1'b1;
      else                 rpt_next = rpt + RPT_W'(1);
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  // w_out is refreshed only on a step edge, so switch activity between
  // presses never reaches the downstream FSM.
  always_comb begin
    step_next = press_accept | rpt_fire;
    w_next    = step_next ? sw_s : w_q;
  end

  assign bus.step      = step_q;
  assign bus.w_out     = w_q;
  assign bus.btn_level = (state == PRESSED) || (state == RELEASE_WAIT);

endmodule

// File: tb/tb_step_pulse_conditioner.sv
// -----------------------------------------------------------------------------
// tb_step_pulse_conditioner
//   Scoreboard bench for step_pulse_conditioner with DEBOUNCE_CYCLES=4 and
//   REPEAT_CYCLES=10. The reference model describes the button as a run-length
//   process: an input level that differs from the accepted level for
//   DEBOUNCE_CYCLES+1 consecutive synchronized samples flips the accepted
//   level; a 0->1 flip is a step. Expected steps go into a queue that an
//   independent monitor drains whenever the DUT raises step.
// -----------------------------------------------------------------------------
module tb_step_pulse_conditioner;

  localparam int unsigned DEB = 4;
  localparam int unsigned RPT = 10;
`ifdef STEP_PULSE_REPEAT_EN
  localparam bit REPEAT_ON = 1'b1;
`else
  localparam bit REPEAT_ON = 1'b0;
`endif

  typedef struct {
    int unsigned edge_no;
    logic        w;
  } exp_t;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  int unsigned cyc   = 0;
  int          checks = 0;
  int          errors = 0;

  exp_t        exp_q[$];

  // Reference model state.
  logic        btn_dly[$];
  logic        sw_dly[$];
  logic        m_level;
  int          m_run;
  int          m_held;
  logic        m_w;

  step_pulse_conditioner_if bus ();

  step_pulse_conditioner #(
    .DEBOUNCE_CYCLES (DEB)
`ifdef STEP_PULSE_REPEAT_EN
    ,
    .REPEAT_CYCLES   (RPT)
`endif
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    btn_dly = '{1'b0, 1'b0};
    sw_dly  = '{1'b0, 1'b0};
    m_level = 1'b0;
    m_run   = 0;
    m_held  = 0;
    m_w     = 1'b0;
  endfunction

  // Predict the effect of the next rising edge given the inputs applied now.
  function automatic void model_edge(input logic b, input logic s);
    logic bs;
    logic ss;
    btn_dly.push_back(b);
    sw_dly.push_back(s);
    bs = btn_dly.pop_front();
    ss = sw_dly.pop_front();
    if (bs != m_level) begin
      m_held = 0;
      m_run++;
      if (m_run == int'(DEB) + 1) begin
        m_run   = 0;
        m_level = ~m_level;
        if (m_level) begin
          m_w = ss;
          exp_q.push_back('{cyc + 1, ss});
        end
      end
    end else begin
      if (REPEAT_ON && m_level && m_run == 0) begin
        m_held++;
        if (m_held == int'(RPT)) begin
          m_held = 0;
          m_w    = ss;
          exp_q.push_back('{cyc + 1, ss});
        end
      end
      m_run = 0;
    end
  endfunction

  task automatic tick(input logic b, input logic s);
    @(negedge clk);
    check("btn_level", bus.btn_level, m_level);
    check("w_out", bus.w_out, m_w);
    bus.btn_in = b;
    bus.sw_in  = s;
    model_edge(b, s);
  endtask

  task automatic hold(input logic b, input logic s, input int n);
    for (int i = 0; i < n; i++) tick(b, s);
  endtask

  // Assert reset off the sampling edge, check that outputs clear, then release
  // on a falling edge with the given inputs already applied.
  task automatic apply_reset(input int n, input logic b, input logic s);
    @(negedge clk);
    #2;
    reset      = 1'b1;
    bus.btn_in = b;
    bus.sw_in  = s;
    #1;
    check("rst_step", bus.step, 1'b0);
    check("rst_w_out", bus.w_out, 1'b0);
    check("rst_btn_level", bus.btn_level, 1'b0);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("rst_step_hold", bus.step, 1'b0);
      check("rst_level_hold", bus.btn_level, 1'b0);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    model_edge(b, s);
  endtask

  // Monitor: every step the DUT shows must match the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.step === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_step: step=1 at edge %0d, expected no step", cyc);
        end else begin
          e = exp_q.pop_front();
          check("step_edge", cyc, e.edge_no);
          check("step_w", bus.w_out, e.w);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic lvl;
    int   len;
    bus.btn_in = 1'b0;
    bus.sw_in  = 1'b0;
    model_reset();

    apply_reset(3, 1'b0, 1'b0);

    // Idle: no steps with the button released.
    hold(1'b0, 1'b0, 20);

    // Clean press with sw high, then a release bounce while pressed.
    hold(1'b1, 1'b1, 12);
    hold(1'b0, 1'b0, 2);
    hold(1'b1, 1'b0, 5);
    hold(1'b0, 1'b0, 8);

    // Press bounce shorter than the window: rejected.
    hold(1'b1, 1'b1, 2);
    hold(1'b0, 1'b1, 1);
    hold(1'b1, 1'b1, 2);
    hold(1'b0, 1'b0, 10);

    // Reset in the middle of PRESS_WAIT with the button still held.
    hold(1'b1, 1'b0, 4);
    apply_reset(3, 1'b1, 1'b1);
    hold(1'b1, 1'b1, 12);
    hold(1'b0, 1'b0, 10);

    // Long hold: single step, or repeats every RPT cycles when enabled.
    for (int i = 0; i < 40; i++) tick(1'b1, 1'($urandom_range(0, 1)));
    hold(1'b0, 1'b0, 10);

    // Randomized bouncy activity with occasional resets.
    for (int seg = 0; seg < 150; seg++) begin
      if ($urandom_range(0, 39) == 0) begin
        apply_reset($urandom_range(1, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      lvl = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 14);
      for (int i = 0; i < len; i++) tick(lvl, 1'($urandom_range(0, 1)));
    end

    // Drain: let any pending press/release finish, then nothing may remain.
    hold(1'b0, 1'b0, 2 * DEB + 6);
    check("pending_steps", exp_q.size(), 0);
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      $display("FAIL missed_step: no step seen, expected step at edge %0d", e.edge_no);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
